// File: rtl/uart_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================
// Package : uart_arb_pkg
// Shared types and defaults for the UART TX arbiter.
// Rev     : 1.0
// ============================================================
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int DEF_NUM_REQ      = 4;
  localparam int DEF_BUSY_TIMEOUT = 15;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================
// Module : rr_arbiter
// Combinational pick of the first request at or after ptr_i.
// Rev    : 1.0
// ============================================================
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  int   j;
  logic found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!found && req_i[j]) begin
        found      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IW'(j);
      end
    end
    valid_o = found;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================
// Module : uart_tx_arbiter
// Round-robin sharing of one UART transmitter among NUM_REQ sources.
// Rev    : 1.0
// ============================================================
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int NUM_REQ      = DEF_NUM_REQ,
  parameter  int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT,
  localparam int IW           = $clog2(NUM_REQ),
  localparam int CW           = $clog2(BUSY_TIMEOUT + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [NUM_REQ-1:0]   req_par_en_i,
  input  logic [NUM_REQ-1:0]   req_par_typ_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [7:0]           tx_p_data_o,
  output logic                 tx_data_valid_o,
  output logic                 tx_par_en_o,
  output logic                 tx_par_typ_o,
  input  logic                 tx_busy_i,
  output logic [IW-1:0]        grant_id_o,
  output logic                 timeout_err_o
);

  state_e              state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [7:0]          data_q;
  logic                par_en_q, par_typ_q;
  logic [IW-1:0]       grant_q;

  logic [NUM_REQ-1:0]  arb_grant;
  logic [IW-1:0]       arb_idx;
  logic                arb_valid;
  logic                accept;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req_i   (req_valid_i),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  assign accept = (state_q == ST_IDLE) && !tx_busy_i && arb_valid;
  assign ptr_d  = (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Frame configuration only moves on an accepting edge, so it stays put for the whole frame.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= PAR_EVEN;
      grant_q   <= '0;
    end else if (accept) begin
      ptr_q     <= ptr_d;
      data_q    <= req_data_i[{arb_idx, 3'b000} +: 8];
      par_en_q  <= req_par_en_i[arb_idx];
      par_typ_q <= req_par_typ_i[arb_idx];
      grant_q   <= arb_idx;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_BUSY;
        cnt_d   = '0;
      end
      ST_WAIT_BUSY: begin
        if (tx_busy_i) begin
          state_d = ST_WAIT_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CW'(BUSY_TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o     = accept ? arb_grant : '0;
    tx_data_valid_o = (state_q == ST_ISSUE);
    tx_p_data_o     = data_q;
    tx_par_en_o     = par_en_q;
    tx_par_typ_o    = par_typ_q;
    grant_id_o      = grant_q;
    timeout_err_o   = err_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================
// Module : tb_uart_tx_arbiter
// Directed self-checking bench for uart_tx_arbiter with a simple UART busy model.
// Rev    : 1.0
// ============================================================
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] req_data;
  logic [3:0]  req_valid, req_par_en, req_par_typ, req_ready;
  logic [7:0]  tx_p_data;
  logic        tx_dv, tx_par_en, tx_par_typ, timeout_err;
  logic        tx_busy;
  logic [1:0]  grant_id;

  bit model_en = 1'b1;
  int busy_len = 11;
  int checks   = 0;
  int errors   = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(4), .BUSY_TIMEOUT(15)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req_data_i      (req_data),
    .req_valid_i     (req_valid),
    .req_par_en_i    (req_par_en),
    .req_par_typ_i   (req_par_typ),
    .req_ready_o     (req_ready),
    .tx_p_data_o     (tx_p_data),
    .tx_data_valid_o (tx_dv),
    .tx_par_en_o     (tx_par_en),
    .tx_par_typ_o    (tx_par_typ),
    .tx_busy_i       (tx_busy),
    .grant_id_o      (grant_id),
    .timeout_err_o   (timeout_err)
  );

  // UART model: BUSY rises one cycle after the start pulse, stays high busy_len cycles.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (model_en && tx_dv === 1'b1 && !rst) begin
        @(negedge clk);
        tx_busy = 1'b1;
        for (int k = 0; k < busy_len; k++) begin
          @(negedge clk);
          if (rst) break;
        end
        tx_busy = 1'b0;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b want %b", req_ready, 4'b0000); end
    checks++; if (tx_p_data !== 8'h00) begin errors++; $display("FAIL reset_p_data got %h want %h", tx_p_data, 8'h00); end
    checks++; if (tx_dv !== 1'b0) begin errors++; $display("FAIL reset_dv got %b want 0", tx_dv); end
    checks++; if (tx_par_en !== 1'b0) begin errors++; $display("FAIL reset_par_en got %b want 0", tx_par_en); end
    checks++; if (tx_par_typ !== 1'b0) begin errors++; $display("FAIL reset_par_typ got %b want 0", tx_par_typ); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id got %0d want 0", grant_id); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err got %b want 0", timeout_err); end
    rst = 1'b0;
    tick();
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL idle_no_valid_ready got %b want %b", req_ready, 4'b0000); end
  endtask

  task automatic test_single();
    int dv_cnt;
    bit stable;
    req_data[23:16] = 8'h2B;
    req_par_en      = 4'b0100;
    req_par_typ     = 4'b0000;
    req_valid       = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got %b want %b", req_ready, 4'b0100); end
    tick();
    checks++; if (tx_dv !== 1'b1) begin errors++; $display("FAIL single_dv got %b want 1", tx_dv); end
    checks++; if (tx_p_data !== 8'h2B) begin errors++; $display("FAIL single_p_data got %h want %h", tx_p_data, 8'h2B); end
    checks++; if (tx_par_en !== 1'b1 || tx_par_typ !== 1'b0) begin errors++; $display("FAIL single_par got en=%b typ=%b want en=1 typ=0", tx_par_en, tx_par_typ); end
    checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL single_grant_id got %0d want 2", grant_id); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_ready_drop got %b want %b", req_ready, 4'b0000); end
    req_valid = 4'b0000;
    dv_cnt = 1;
    stable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (tx_dv === 1'b1) dv_cnt++;
      if (tx_p_data !== 8'h2B || tx_par_en !== 1'b1 || tx_par_typ !== 1'b0) stable = 1'b0;
    end
    checks++; if (dv_cnt != 1) begin errors++; $display("FAIL single_dv_count got %0d want 1", dv_cnt); end
    checks++; if (!stable) begin errors++; $display("FAIL single_stability got unstable want stable"); end
  endtask

  task automatic test_all_valid();
    logic [3:0] exp_rdy [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] exp_id  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [7:0] exp_byte[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    logic       exp_en  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic       exp_typ [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    int n;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_data    = {8'h44, 8'h33, 8'h22, 8'h11};
    req_par_en  = 4'b0101;
    req_par_typ = 4'b0011;
    req_valid   = 4'b1111;
    #1;
    n = 0;
    for (int c = 0; c < 150 && n < 5; c++) begin
      if (req_ready !== 4'b0000) begin
        checks++; if (req_ready !== exp_rdy[n]) begin errors++; $display("FAIL rr_ready[%0d] got %b want %b", n, req_ready, exp_rdy[n]); end
        tick();
        checks++; if (grant_id !== exp_id[n] || tx_p_data !== exp_byte[n]) begin errors++; $display("FAIL rr_grant[%0d] got id=%0d data=%h want id=%0d data=%h", n, grant_id, tx_p_data, exp_id[n], exp_byte[n]); end
        checks++; if (tx_par_en !== exp_en[n] || tx_par_typ !== exp_typ[n]) begin errors++; $display("FAIL rr_par[%0d] got en=%b typ=%b want en=%b typ=%b", n, tx_par_en, tx_par_typ, exp_en[n], exp_typ[n]); end
        checks++; if (tx_dv !== 1'b1 || req_ready !== 4'b0000) begin errors++; $display("FAIL rr_pulse[%0d] got dv=%b ready=%b want dv=1 ready=0000", n, tx_dv, req_ready); end
        n++;
        if (n == 5) req_valid = 4'b0000;
      end else begin
        tick();
      end
    end
    checks++; if (n != 5) begin errors++; $display("FAIL rr_grant_count got %0d want 5", n); end
    repeat (20) tick();
  endtask

  task automatic test_valid_during_tx();
    bit bad;
    int c;
    req_data[7:0] = 8'h5A;
    req_par_en    = 4'b0000;
    req_par_typ   = 4'b0000;
    req_valid     = 4'b0001;
    #1;
    tick();
    checks++; if (tx_dv !== 1'b1 || tx_p_data !== 8'h5A) begin errors++; $display("FAIL vdt_first got dv=%b data=%h want dv=1 data=5a", tx_dv, tx_p_data); end
    req_valid = 4'b0000;
    c = 0;
    while (tx_busy !== 1'b1 && c < 10) begin tick(); c++; end
    req_data[15:8] = 8'h29;
    req_valid      = 4'b0010;
    #1;
    bad = 1'b0;
    c = 0;
    while (tx_busy === 1'b1 && c < 30) begin
      if (req_ready !== 4'b0000 || tx_p_data !== 8'h5A) bad = 1'b1;
      tick();
      c++;
    end
    checks++; if (bad) begin errors++; $display("FAIL vdt_hold got ready/data disturbed want ready=0000 data=5a"); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL vdt_late_valid got %b want %b", req_ready, 4'b0000); end
    tick();
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL vdt_idle_ready got %b want %b", req_ready, 4'b0010); end
    tick();
    checks++; if (tx_dv !== 1'b1 || tx_p_data !== 8'h29 || grant_id !== 2'd1) begin errors++; $display("FAIL vdt_second got dv=%b data=%h id=%0d want dv=1 data=29 id=1", tx_dv, tx_p_data, grant_id); end
    req_valid = 4'b0000;
    repeat (20) tick();
  endtask

  task automatic test_timeout();
    model_en        = 1'b0;
    req_data[31:24] = 8'h3C;
    req_valid       = 4'b1000;
    #1;
    tick();
    checks++; if (tx_dv !== 1'b1 || tx_p_data !== 8'h3C) begin errors++; $display("FAIL to_pulse got dv=%b data=%h want dv=1 data=3c", tx_dv, tx_p_data); end
    req_valid = 4'b0000;
    tick();
    repeat (14) tick();
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_early got %b want 0", timeout_err); end
    tick();
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_flag got %b want 1", timeout_err); end
    model_en      = 1'b1;
    req_data[7:0] = 8'h0F;
    req_valid     = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL to_back_idle got %b want %b", req_ready, 4'b0001); end
    tick();
    checks++; if (tx_dv !== 1'b1 || tx_p_data !== 8'h0F || grant_id !== 2'd0) begin errors++; $display("FAIL to_next got dv=%b data=%h id=%0d want dv=1 data=0f id=0", tx_dv, tx_p_data, grant_id); end
    req_valid = 4'b0000;
    repeat (20) tick();
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky got %b want 1", timeout_err); end
  endtask

  task automatic test_reset_mid();
    req_data[23:16] = 8'h77;
    req_par_en      = 4'b0100;
    req_par_typ     = 4'b0100;
    req_valid       = 4'b0100;
    #1;
    tick();
    req_valid = 4'b0000;
    tick();
    tick();
    tick();
    checks++; if (tx_p_data !== 8'h77 || grant_id !== 2'd2) begin errors++; $display("FAIL rm_pre got data=%h id=%0d want data=77 id=2", tx_p_data, grant_id); end
    rst = 1'b1;
    #1;
    checks++; if (tx_p_data !== 8'h00 || tx_dv !== 1'b0) begin errors++; $display("FAIL rm_data got data=%h dv=%b want data=00 dv=0", tx_p_data, tx_dv); end
    checks++; if (tx_par_en !== 1'b0 || tx_par_typ !== 1'b0) begin errors++; $display("FAIL rm_par got en=%b typ=%b want en=0 typ=0", tx_par_en, tx_par_typ); end
    checks++; if (grant_id !== 2'd0 || timeout_err !== 1'b0) begin errors++; $display("FAIL rm_regs got id=%0d err=%b want id=0 err=0", grant_id, timeout_err); end
    tick();
    tick();
    rst = 1'b0;
    req_data[15:8]  = 8'hA1;
    req_data[31:24] = 8'hA3;
    req_valid       = 4'b1010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rm_ptr_ready got %b want %b", req_ready, 4'b0010); end
    tick();
    checks++; if (tx_dv !== 1'b1 || tx_p_data !== 8'hA1 || grant_id !== 2'd1) begin errors++; $display("FAIL rm_first got dv=%b data=%h id=%0d want dv=1 data=a1 id=1", tx_dv, tx_p_data, grant_id); end
    req_valid = 4'b0000;
    repeat (20) tick();
  endtask

  initial begin
    req_data    = '0;
    req_valid   = '0;
    req_par_en  = '0;
    req_par_typ = '0;
    test_reset();
    test_single();
    test_all_valid();
    test_valid_during_tx();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
